// File: rtl/npu_array_scheduler_if.sv
// Control and result-stream bundle between the host/FIFO side and the
// matrix-pass scheduler.
interface npu_array_scheduler_if #(
    parameter int N  = 2,
    parameter int KW = 8,
    parameter int OW = 17
);
    localparam int IW = $clog2(N*N);

    logic              start;
    logic [KW-1:0]     cfg_k;
    logic              busy;
    logic              done;
    logic              pe_clr;
    logic              feed_en;
    logic [N-1:0]      a_pop;
    logic [N-1:0]      b_pop;
    logic [N*N*OW-1:0] pe_out;
    logic              res_valid;
    logic              res_ready;
    logic [OW-1:0]     res_data;
    logic [IW-1:0]     res_idx;
    logic              res_last;

    modport master (
        output start, cfg_k, pe_out, res_ready,
        input  busy, done, pe_clr, feed_en, a_pop, b_pop,
               res_valid, res_data, res_idx, res_last
    );

    modport slave (
        input  start, cfg_k, pe_out, res_ready,
        output busy, done, pe_clr, feed_en, a_pop, b_pop,
               res_valid, res_data, res_idx, res_last
    );
endinterface

// File: rtl/npu_array_scheduler.sv
// Sequences one systolic matrix-multiply pass: clear, skewed operand feed,
// wavefront flush, then drain of all N*N PE results over valid/ready.
module npu_array_scheduler #(
    parameter int N    = 2,
    parameter int KW   = 8,
    parameter int OW   = 17,
    parameter int PIPE = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    npu_array_scheduler_if.slave   io_bus
);
    localparam int IW = $clog2(N*N);
    // Step counter is shared by FEED and FLUSH; sized for k+N-2 at k=2^KW-1.
    localparam int TW = $clog2((1 << KW) + N + PIPE);
    localparam int CW = TW + 1;
    localparam logic [TW-1:0] FLUSH_LAST = TW'(N - 2 + PIPE);
    localparam logic [IW-1:0] IDX_LAST   = IW'(N*N - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_FEED, S_FLUSH, S_DRAIN, S_DONE
    } state_t;

    state_t          r_state;
    logic [KW-1:0]   r_k;
    logic [TW-1:0]   r_t;
    logic [IW-1:0]   r_idx;

    logic [TW-1:0]   w_feed_last;
    logic [N-1:0]    w_pop;
    logic [OW-1:0]   w_pe [N*N];

    assign w_feed_last = TW'(r_k) + TW'(N - 2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_k     <= '0;
            r_t     <= '0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (io_bus.start) begin
                        r_k     <= io_bus.cfg_k;
                        r_state <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    r_t     <= '0;
                    r_idx   <= '0;
                    // An empty inner dimension drains the freshly cleared zeros.
                    r_state <= (r_k != '0) ? S_FEED : S_DRAIN;
                end
                S_FEED: begin
                    if (r_t == w_feed_last) begin
                        r_t     <= '0;
                        r_state <= S_FLUSH;
                    end else begin
                        r_t <= r_t + 1'b1;
                    end
                end
                S_FLUSH: begin
                    if (r_t == FLUSH_LAST) begin
                        r_t     <= '0;
                        r_idx   <= '0;
                        r_state <= S_DRAIN;
                    end else begin
                        r_t <= r_t + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (io_bus.res_ready) begin
                        if (r_idx == IDX_LAST) begin
                            r_idx   <= '0;
                            r_state <= S_DONE;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Lane gi is active for k consecutive steps starting at step gi (skew).
    for (genvar gi = 0; gi < N; gi++) begin : g_pop
        logic w_in_window;
        assign w_in_window = ({1'b0, r_t} >= CW'(gi)) &&
                             ({1'b0, r_t} <  CW'(gi) + CW'(r_k));
        assign w_pop[gi] = (r_state == S_FEED) && w_in_window;
    end

    for (genvar gi = 0; gi < N*N; gi++) begin : g_pe
        assign w_pe[gi] = io_bus.pe_out[gi*OW +: OW];
    end

    assign io_bus.busy      = (r_state == S_CLEAR) || (r_state == S_FEED) ||
                              (r_state == S_FLUSH) || (r_state == S_DRAIN);
    assign io_bus.done      = (r_state == S_DONE);
    assign io_bus.pe_clr    = (r_state == S_CLEAR);
    assign io_bus.feed_en   = (r_state == S_FEED) || (r_state == S_FLUSH);
    assign io_bus.a_pop     = w_pop;
    assign io_bus.b_pop     = w_pop;
    assign io_bus.res_valid = (r_state == S_DRAIN);
    assign io_bus.res_idx   = r_idx;
    assign io_bus.res_last  = (r_state == S_DRAIN) && (r_idx == IDX_LAST);
    assign io_bus.res_data  = w_pe[r_idx];
endmodule

// File: tb/tb_npu_array_scheduler.sv
// Directed bench: behavioural 2x2 systolic PE array with preloaded operand
// FIFOs around the scheduler; results and timeline checked against hand values.
module tb_npu_array_scheduler;
    localparam int N    = 2;
    localparam int KW   = 8;
    localparam int OW   = 17;
    localparam int PIPE = 1;
    localparam int MAXK = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    npu_array_scheduler_if #(.N(N), .KW(KW), .OW(OW)) bus ();

    npu_array_scheduler #(.N(N), .KW(KW), .OW(OW), .PIPE(PIPE)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Operand datasets: A is N x K (row lanes), B is K x N (column lanes).
    int A1 [N][3] = '{'{1, 1, 1}, '{2, 2, 2}};
    int B1 [3][N] = '{'{1, 2}, '{1, 2}, '{1, 2}};
    int A2 [N][3] = '{'{1, 2, 3}, '{4, 5, 6}};
    int B2 [3][N] = '{'{1, 0}, '{0, 1}, '{1, 1}};
    int EXP1 [4]  = '{3, 6, 6, 12};
    int EXP2 [4]  = '{4, 5, 10, 11};
    int EXP0 [4]  = '{0, 0, 0, 0};
    int POP_NOM [4] = '{1, 3, 3, 2};

    int a_mem [N][MAXK];
    int b_mem [N][MAXK];

    // Behavioural PE array model: operands shift right/down, MAC at each advance.
    int a_rd  [N];
    int b_rd  [N];
    int a_reg [N][N];
    int b_reg [N][N];
    int acc   [N][N];
    int hs_cnt;
    int done_cnt;

    always @(posedge clk) begin
        int na   [N][N];
        int nb   [N][N];
        int nacc [N][N];
        int ar   [N];
        int br   [N];
        int ain;
        int bin;
        if (bus.pe_clr) begin
            for (int r = 0; r < N; r++) begin
                a_rd[r] <= 0;
                b_rd[r] <= 0;
                for (int c = 0; c < N; c++) begin
                    a_reg[r][c] <= 0;
                    b_reg[r][c] <= 0;
                    acc[r][c]   <= 0;
                end
            end
        end else if (bus.feed_en) begin
            na = a_reg; nb = b_reg; nacc = acc; ar = a_rd; br = b_rd;
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    if (c == 0)
                        ain = (bus.a_pop[r] && a_rd[r] < MAXK) ? a_mem[r][a_rd[r]] : 0;
                    else
                        ain = a_reg[r][c-1];
                    if (r == 0)
                        bin = (bus.b_pop[c] && b_rd[c] < MAXK) ? b_mem[c][b_rd[c]] : 0;
                    else
                        bin = b_reg[r-1][c];
                    na[r][c]   = ain;
                    nb[r][c]   = bin;
                    nacc[r][c] = acc[r][c] + ain * bin;
                end
                if (bus.a_pop[r]) ar[r] = a_rd[r] + 1;
                if (bus.b_pop[r]) br[r] = b_rd[r] + 1;
            end
            a_reg <= na; b_reg <= nb; acc <= nacc; a_rd <= ar; b_rd <= br;
        end
        if (bus.res_valid && bus.res_ready) hs_cnt <= hs_cnt + 1;
        if (bus.done) done_cnt <= done_cnt + 1;
    end

    always_comb begin
        bus.pe_out = '0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                bus.pe_out[(r*N+c)*OW +: OW] = acc[r][c][OW-1:0];
    end

    task automatic check_val(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int sel);
        for (int i = 0; i < N; i++)
            for (int k = 0; k < MAXK; k++) begin
                a_mem[i][k] = 0;
                b_mem[i][k] = 0;
            end
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 3; k++) begin
                a_mem[i][k] = (sel == 1) ? A1[i][k] : A2[i][k];
                b_mem[i][k] = (sel == 1) ? B1[k][i] : B2[k][i];
            end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, ".busy"},      bus.busy, 0);
        check_val({tag, ".done"},      bus.done, 0);
        check_val({tag, ".pe_clr"},    bus.pe_clr, 0);
        check_val({tag, ".feed_en"},   bus.feed_en, 0);
        check_val({tag, ".a_pop"},     bus.a_pop, 0);
        check_val({tag, ".b_pop"},     bus.b_pop, 0);
        check_val({tag, ".res_valid"}, bus.res_valid, 0);
        check_val({tag, ".res_last"},  bus.res_last, 0);
        check_val({tag, ".res_idx"},   bus.res_idx, 0);
    endtask

    // One full pass from an IDLE cycle; optional stall and start pokes while busy.
    task automatic run_pass(input string nm, input int k, input int exp_res[4],
                            input int stall_idx, input bit poke);
        int cyc = 0;
        int feed_cyc = 0;
        int pop_sum = 0;
        int seen = 0;
        int hs0 = hs_cnt;
        int d0 = done_cnt;
        bit stalled = 0;
        logic [OW-1:0] held;
        bus.cfg_k = KW'(k);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check_val({nm, ".pe_clr"}, bus.pe_clr, 1);
        while (!bus.res_valid && cyc < 600) begin
            if (bus.feed_en) feed_cyc++;
            pop_sum += $countones(bus.a_pop) + $countones(bus.b_pop);
            bus.start = poke && bus.feed_en && (bus.a_pop == '0);
            tick();
            bus.start = 1'b0;
            cyc++;
        end
        check_val({nm, ".feed_cycles"}, feed_cyc, (k == 0) ? 0 : k + N - 1 + N - 1 + PIPE);
        check_val({nm, ".pop_total"}, pop_sum, 2 * N * k);
        while (seen < 4 && cyc < 600) begin
            if (!stalled && int'(bus.res_idx) == stall_idx) begin
                stalled = 1;
                held = bus.res_data;
                bus.res_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    tick();
                    check_val({nm, ".stall_idx"}, bus.res_idx, stall_idx);
                    check_val({nm, ".stall_data"}, bus.res_data, held);
                    check_val({nm, ".stall_done"}, bus.done, 0);
                end
                bus.res_ready = 1'b1;
            end
            check_val({nm, ".valid"}, bus.res_valid, 1);
            check_val({nm, ".idx"}, bus.res_idx, seen);
            check_val({nm, ".data"}, bus.res_data, exp_res[seen]);
            check_val({nm, ".last"}, bus.res_last, (seen == 3) ? 1 : 0);
            bus.start = poke && (seen == 2);
            tick();
            bus.start = 1'b0;
            seen++;
            cyc++;
        end
        check_val({nm, ".timeout"}, (cyc < 600) ? 1 : 0, 1);
        check_val({nm, ".done"}, bus.done, 1);
        check_val({nm, ".busy_done"}, bus.busy, 0);
        tick();
        check_val({nm, ".done_one_cycle"}, bus.done, 0);
        check_val({nm, ".handshakes"}, hs_cnt - hs0, 4);
        check_val({nm, ".done_pulses"}, done_cnt - d0, 1);
        $display("pass %s k=%0d results %0d %0d %0d %0d checked", nm, k,
                 exp_res[0], exp_res[1], exp_res[2], exp_res[3]);
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.cfg_k     = '0;
        bus.res_ready = 1'b1;
        load(1);
        repeat (2) tick();
        check_idle_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Nominal pass with full cycle timeline.
        bus.cfg_k = 8'd3;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check_val("nom.c1.pe_clr", bus.pe_clr, 1);
        check_val("nom.c1.busy", bus.busy, 1);
        check_val("nom.c1.feed_en", bus.feed_en, 0);
        for (int t = 0; t < 4; t++) begin
            tick();
            check_val("nom.feed.a_pop", bus.a_pop, POP_NOM[t]);
            check_val("nom.feed.b_pop", bus.b_pop, POP_NOM[t]);
            check_val("nom.feed.feed_en", bus.feed_en, 1);
        end
        for (int t = 0; t < 2; t++) begin
            tick();
            check_val("nom.flush.feed_en", bus.feed_en, 1);
            check_val("nom.flush.pops", {bus.a_pop, bus.b_pop}, 0);
            check_val("nom.flush.valid", bus.res_valid, 0);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val("nom.drain.valid", bus.res_valid, 1);
            check_val("nom.drain.idx", bus.res_idx, i);
            check_val("nom.drain.data", bus.res_data, EXP1[i]);
            check_val("nom.drain.last", bus.res_last, (i == 3) ? 1 : 0);
            check_val("nom.drain.done", bus.done, 0);
        end
        tick();
        check_val("nom.c12.done", bus.done, 1);
        check_val("nom.c12.busy", bus.busy, 0);
        tick();
        $display("pass nominal k=3 timeline checked");

        // Reset mid-FEED aborts immediately.
        load(2);
        bus.cfg_k = 8'd3;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        check_val("abort.pre.feed_en", bus.feed_en, 1);
        #1 rst = 1'b1;
        #1 check_idle_outputs("abort");
        @(negedge clk);
        rst = 1'b0;
        tick();
        run_pass("after_abort", 3, EXP2, -1, 0);

        run_pass("backpressure", 3, EXP2, 1, 0);
        run_pass("start_busy", 3, EXP2, -1, 1);
        run_pass("k_zero", 0, EXP0, -1, 0);

        // Back-to-back: second start lands in the IDLE cycle right after done.
        load(1);
        run_pass("b2b_first", 3, EXP1, -1, 0);
        load(2);
        run_pass("b2b_second", 3, EXP2, -1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
